id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have no parameters; all data paths are 32 bits and register specifiers are 5 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 stall  input  1  hold: pipeline register keeps its contents.
REQ-005 flush  input  1  load a bubble (branch/jump squash).
REQ-006 id_valid  input  1  decode slot holds a real instruction.
REQ-007 id_rs_data, id_rt_data, id_imm  input  32 each  register-file operands; sign-extended immediate.
REQ-008 id_rs, id_rt, id_rd  input  5 each  source specifiers; destination specifier.
REQ-009 id_alu_control  input  4  ALU operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR).
REQ-010 id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write  input  1 each  decode control bits.
REQ-011 exmem_reg_write, memwb_reg_write  input  1 each  later stages will write a register.
REQ-012 exmem_rd, memwb_rd  input  5 each  their destinations.
REQ-013 exmem_result, memwb_data  input  32 each  their forwardable values.
REQ-014 ALU_in1, ALU_in2  output  32 each  ALU operands.
REQ-015 ALU_control  output  4  registered operation code.
REQ-016 ex_store_data  output  32  forwarded rt value for stores.
REQ-017 ex_dest  output  5  id_rd if reg_dst else id_rt, registered.
REQ-018 ex_reg_write, ex_mem_read, ex_mem_write, ex_valid  output  1 each  registered controls and valid.
REQ-019 load_use_stall  output  1  combinational load-use hazard request to fetch/decode.

Function
REQ-020 Stage register fields SHALL be rs_data, rt_data, imm, rs, rt, dest, alu_control, alu_src, reg_write, mem_read, mem_write, valid.
REQ-021 Per edge, priority SHALL be: reset, then flush, then stall, then load_use_stall, then normal load.
REQ-022 Normal load SHALL capture all id_* fields with one-cycle latency; ex_valid = id_valid.
REQ-023 Stall without flush SHALL hold every field unchanged.
REQ-024 Flush, or load_use_stall without stall, SHALL load a bubble: valid, reg_write, mem_read, mem_write = 0, alu_control = 0010, data fields and specifiers = 0.
REQ-025 load_use_stall SHALL equal ex_valid & ex_mem_read & (ex_dest != 0) & id_valid & (ex_dest == id_rs | ex_dest == id_rt).
REQ-026 Forward A (and forward B identically, using the registered rt) SHALL be combinational on the registered rs: exmem_result if exmem_reg_write & exmem_rd != 0 & exmem_rd == rs; else memwb_data if memwb_reg_write & memwb_rd != 0 & memwb_rd == rs; else rs_data.
REQ-027 EX/MEM forwarding SHALL win when both later stages match the same register.
REQ-028 ALU_in1 SHALL equal forward A; ALU_in2 SHALL be imm when alu_src = 1, else forward B; ex_store_data SHALL always be forward B.
REQ-029 Register 0 SHALL never be a forwarding source; its operand comes from the stage register.
REQ-030 A bubble SHALL present ALU_in1 = ALU_in2 = 0 unless forwarded, and no write/memory control.

Reset
REQ-031 With rst_n low at an edge, every field SHALL clear to zero except alu_control = 0010; ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall = 0 in the following cycle.
REQ-032 Reset SHALL override stall and flush, and mid-stall reset SHALL discard the held instruction.

Verification
REQ-033 Load add rs=8 (0x5), rt=9 (0x3), ctrl 0010, alu_src 0, no hazards -> next cycle ALU_in1=5, ALU_in2=3, ALU_control=0010, ex_valid=1.
REQ-034 Registered rs=8; exmem_rd=8 (0x11) and memwb_rd=8 (0x22), both writing -> ALU_in1=0x11; drop exmem_reg_write -> 0x22.
REQ-035 Registered rs=0; exmem_rd=0 writing 0xFFFF -> ALU_in1 = stage-register value 0.
REQ-036 Stage holds lw dest=10; id_rs=10 valid -> load_use_stall=1; next edge ex_valid=0, ex_mem_read=0.
REQ-037 stall=1 and flush=1 together -> bubble loaded; stall only for 3 cycles -> outputs constant.
REQ-038 rst_n low during stall with valid sw held -> next cycle ex_valid=0, ex_mem_write=0, ALU_control=0010.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with operand forwarding and
//               load-use hazard detection.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_alu_control,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        exmem_reg_write,
  input  logic        memwb_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_data,
  output logic [31:0] ALU_in1,
  output logic [31:0] ALU_in2,
  output logic [3:0]  ALU_control,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_valid,
  output logic        load_use_stall
);

  localparam logic [3:0] ALU_ADD = 4'b0010;

  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  dest_q, dest_d;
  logic [3:0]  alu_control_q, alu_control_d;
  logic        alu_src_q, alu_src_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        valid_q, valid_d;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // A load in EX whose destination feeds the instruction now in decode.
  assign load_use_stall = valid_q & mem_read_q & (dest_q != 5'd0) & id_valid &
                          ((dest_q == id_rs) | (dest_q == id_rt));

  always_comb begin
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    imm_d         = imm_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    dest_d        = dest_q;
    alu_control_d = alu_control_q;
    alu_src_d     = alu_src_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    valid_d       = valid_q;
    if (flush || (!stall && load_use_stall)) begin
      rs_data_d     = 32'd0;
      rt_data_d     = 32'd0;
      imm_d         = 32'd0;
      rs_d          = 5'd0;
      rt_d          = 5'd0;
      dest_d        = 5'd0;
      alu_control_d = ALU_ADD;
      alu_src_d     = 1'b0;
      reg_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      valid_d       = 1'b0;
    end else if (!stall) begin
      rs_data_d     = id_rs_data;
      rt_data_d     = id_rt_data;
      imm_d         = id_imm;
      rs_d          = id_rs;
      rt_d          = id_rt;
      dest_d        = id_reg_dst ? id_rd : id_rt;
      alu_control_d = id_alu_control;
      alu_src_d     = id_alu_src;
      reg_write_d   = id_reg_write;
      mem_read_d    = id_mem_read;
      mem_write_d   = id_mem_write;
      valid_d       = id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_data_q     <= 32'd0;
      rt_data_q     <= 32'd0;
      imm_q         <= 32'd0;
      rs_q          <= 5'd0;
      rt_q          <= 5'd0;
      dest_q        <= 5'd0;
      alu_control_q <= ALU_ADD;
      alu_src_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      dest_q        <= dest_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      valid_q       <= valid_d;
    end
  end

  // EX/MEM is younger than MEM/WB, so it wins; register 0 is never forwarded.
  always_comb begin
    fwd_a = rs_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs_q))
      fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs_q))
      fwd_a = memwb_data;
  end

  always_comb begin
    fwd_b = rt_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt_q))
      fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt_q))
      fwd_b = memwb_data;
  end

  assign ALU_in1       = fwd_a;
  assign ALU_in2       = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ALU_control   = alu_control_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_valid      = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed self-checking bench for id_ex_stage.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_control;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic [31:0] ALU_in1, ALU_in2, ex_store_data;
  logic [3:0]  ALU_control;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, load_use_stall;

  int checks;
  int errors;

  id_ex_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_alu_control  (id_alu_control),
    .id_alu_src      (id_alu_src),
    .id_reg_dst      (id_reg_dst),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .exmem_reg_write (exmem_reg_write),
    .memwb_reg_write (memwb_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_rd        (memwb_rd),
    .exmem_result    (exmem_result),
    .memwb_data      (memwb_data),
    .ALU_in1         (ALU_in1),
    .ALU_in2         (ALU_in2),
    .ALU_control     (ALU_control),
    .ex_store_data   (ex_store_data),
    .ex_dest         (ex_dest),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_valid        (ex_valid),
    .load_use_stall  (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_control = 4'b0010;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
    exmem_result = 0; memwb_data = 0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [31:0] rs_d,
                             input logic [4:0] rt, input logic [31:0] rt_d,
                             input logic [4:0] rd, input logic [31:0] imm,
                             input logic [3:0] ctrl, input logic alu_src,
                             input logic reg_dst, input logic reg_wr,
                             input logic mem_rd, input logic mem_wr);
    id_valid = 1; id_rs = rs; id_rs_data = rs_d; id_rt = rt; id_rt_data = rt_d;
    id_rd = rd; id_imm = imm; id_alu_control = ctrl; id_alu_src = alu_src;
    id_reg_dst = reg_dst; id_reg_write = reg_wr; id_mem_read = mem_rd; id_mem_write = mem_wr;
  endtask

  task automatic test_reset();
    clear_inputs();
    drive_instr(5'd3, 32'hAAAA, 5'd4, 32'hBBBB, 5'd5, 32'h1, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 0;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
    checks++; if (ALU_control !== 4'b0010) begin errors++; $display("FAIL reset_ctrl: got %b expected 0010", ALU_control); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin errors++; $display("FAIL reset_ctl_bits: got %b expected 000", {ex_reg_write, ex_mem_read, ex_mem_write}); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_lus: got %b expected 0", load_use_stall); end
    checks++; if (ALU_in1 !== 32'd0 || ALU_in2 !== 32'd0 || ex_dest !== 5'd0) begin errors++; $display("FAIL reset_data: in1 %h in2 %h dest %0d expected 0", ALU_in1, ALU_in2, ex_dest); end
    rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_normal_load();
    drive_instr(5'd8, 32'h5, 5'd9, 32'h3, 5'd7, 32'h0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (ALU_in1 !== 32'h5) begin errors++; $display("FAIL load_in1: got %h expected 5", ALU_in1); end
    checks++; if (ALU_in2 !== 32'h3) begin errors++; $display("FAIL load_in2: got %h expected 3", ALU_in2); end
    checks++; if (ALU_control !== 4'b0010 || ex_valid !== 1'b1) begin errors++; $display("FAIL load_ctrl: ctrl %b valid %b expected 0010 1", ALU_control, ex_valid); end
    checks++; if (ex_dest !== 5'd7 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL load_dest: dest %0d wr %b expected 7 1", ex_dest, ex_reg_write); end
    // Immediate operand, rt destination.
    drive_instr(5'd8, 32'h5, 5'd9, 32'h3, 5'd7, 32'hFFFF_FFF0, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (ALU_in2 !== 32'hFFFF_FFF0) begin errors++; $display("FAIL imm_in2: got %h expected fffffff0", ALU_in2); end
    checks++; if (ex_store_data !== 32'h3) begin errors++; $display("FAIL imm_store: got %h expected 3", ex_store_data); end
    checks++; if (ex_dest !== 5'd9 || ALU_control !== 4'b0110) begin errors++; $display("FAIL imm_dest: dest %0d ctrl %b expected 9 0110", ex_dest, ALU_control); end
  endtask

  task automatic test_forwarding();
    drive_instr(5'd8, 32'h5, 5'd9, 32'h3, 5'd7, 32'h0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1;
    exmem_reg_write = 1; exmem_rd = 5'd8; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd8; memwb_data = 32'h22;
    #1;
    checks++; if (ALU_in1 !== 32'h11) begin errors++; $display("FAIL fwd_exmem_wins: got %h expected 11", ALU_in1); end
    exmem_reg_write = 0;
    #1;
    checks++; if (ALU_in1 !== 32'h22) begin errors++; $display("FAIL fwd_memwb: got %h expected 22", ALU_in1); end
    memwb_rd = 5'd9;
    #1;
    checks++; if (ALU_in2 !== 32'h22 || ex_store_data !== 32'h22 || ALU_in1 !== 32'h5) begin errors++; $display("FAIL fwd_b: in2 %h store %h in1 %h expected 22 22 5", ALU_in2, ex_store_data, ALU_in1); end
    exmem_reg_write = 1; exmem_rd = 5'd9; exmem_result = 32'h33;
    #1;
    checks++; if (ALU_in2 !== 32'h33) begin errors++; $display("FAIL fwd_b_exmem: got %h expected 33", ALU_in2); end
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    drive_instr(5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1;
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hFFFF;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_data = 32'hEEEE;
    #1;
    checks++; if (ALU_in1 !== 32'd0 || ALU_in2 !== 32'd0) begin errors++; $display("FAIL zero_reg: in1 %h in2 %h expected 0 0", ALU_in1, ALU_in2); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    // lw into r10 (rt destination).
    drive_instr(5'd1, 32'h100, 5'd10, 32'h0, 5'd0, 32'h4, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_instr(5'd10, 32'h7, 5'd3, 32'h8, 5'd4, 32'h0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    id_valid = 0;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lus_invalid: got %b expected 0", load_use_stall); end
    id_valid = 1; id_rs = 5'd2; id_rt = 5'd10;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lus_rt: got %b expected 1", load_use_stall); end
    id_rt = 5'd3; id_rs = 5'd10;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lus_rs: got %b expected 1", load_use_stall); end
    // Stall beats the load-use bubble: the load stays in place.
    stall = 1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || ex_dest !== 5'd10) begin errors++; $display("FAIL lus_stall_hold: valid %b rd %b dest %0d expected 1 1 10", ex_valid, ex_mem_read, ex_dest); end
    stall = 0;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0 || ALU_control !== 4'b0010) begin errors++; $display("FAIL lus_bubble: valid %b rd %b wr %b ctrl %b expected 0 0 0 0010", ex_valid, ex_mem_read, ex_reg_write, ALU_control); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lus_clear: got %b expected 0", load_use_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ALU_in1 !== 32'h7 || ex_dest !== 5'd4) begin errors++; $display("FAIL lus_reissue: valid %b in1 %h dest %0d expected 1 7 4", ex_valid, ALU_in1, ex_dest); end
    clear_inputs();
  endtask

  task automatic test_flush_stall();
    drive_instr(5'd5, 32'h55, 5'd6, 32'h66, 5'd12, 32'h0, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    stall = 1; flush = 1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || ALU_control !== 4'b0010) begin errors++; $display("FAIL flush_bubble: valid %b mw %b ctrl %b expected 0 0 0010", ex_valid, ex_mem_write, ALU_control); end
    checks++; if (ALU_in1 !== 32'd0 || ALU_in2 !== 32'd0 || ex_dest !== 5'd0) begin errors++; $display("FAIL flush_data: in1 %h in2 %h dest %0d expected 0", ALU_in1, ALU_in2, ex_dest); end
    stall = 0; flush = 0;
    drive_instr(5'd5, 32'h55, 5'd6, 32'h66, 5'd12, 32'h0, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_instr(5'd20 + 5'(i), 32'h900 + i, 5'd21, 32'hABC, 5'd22, 32'h0, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      checks++; if (ALU_in1 !== 32'h55 || ALU_in2 !== 32'h66 || ALU_control !== 4'b0111 || ex_dest !== 5'd12 || ex_valid !== 1'b1 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d: in1 %h in2 %h ctrl %b dest %0d valid %b expected 55 66 0111 12 1", i, ALU_in1, ALU_in2, ALU_control, ex_dest, ex_valid); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_during_stall();
    drive_instr(5'd2, 32'h1000, 5'd3, 32'hBEEF, 5'd0, 32'h8, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (ex_mem_write !== 1'b1 || ex_valid !== 1'b1) begin errors++; $display("FAIL sw_load: mw %b valid %b expected 1 1", ex_mem_write, ex_valid); end
    stall = 1;
    tick();
    rst_n = 0;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || ALU_control !== 4'b0010) begin errors++; $display("FAIL rst_stall: valid %b mw %b ctrl %b expected 0 0 0010", ex_valid, ex_mem_write, ALU_control); end
    rst_n = 1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_store_data !== 32'd0) begin errors++; $display("FAIL rst_discard: valid %b store %h expected 0 0", ex_valid, ex_store_data); end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 0;
    clear_inputs();
    test_reset();
    test_normal_load();
    test_forwarding();
    test_zero_reg();
    test_load_use();
    test_flush_stall();
    test_reset_during_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
